// File: rtl/sr_cmd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : sr_cmd_seq_if
//  Description : Command bundle between a requester and sr_cmd_seq.
//                master : requester; drives raw set_in/clr_in and observes
//                         the s/r pulses and status.
//                slave  : sr_cmd_seq; consumes raw requests and drives
//                         s, r, busy, err.
//  Signals     : set_in, clr_in - raw, asynchronous, possibly bouncy requests
//                s, r           - registered, mutually exclusive pulses
//                busy           - sequencer in PULSE or HOLD
//                err            - sticky conflict flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface sr_cmd_seq_if;
    logic set_in;
    logic clr_in;
    logic s;
    logic r;
    logic busy;
    logic err;

    modport master (
        output set_in,
        output clr_in,
        input  s,
        input  r,
        input  busy,
        input  err
    );

    modport slave (
        input  set_in,
        input  clr_in,
        output s,
        output r,
        output busy,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/sr_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sr_cmd_seq
//  Description : Command stage in front of an SR flip-flop. Each raw request
//                line is synchronised (2 flops) and debounced; the rising
//                edge of the debounced level becomes a pending request. A
//                three-state sequencer turns pending requests into clean,
//                registered, mutually exclusive s/r pulses of PULSE_LEN
//                cycles, each followed by HOLDOFF idle cycles. Clear wins
//                over set when both are pending.
//  Parameters  : DB_CYCLES - debounce length in cycles (>=1)
//                PULSE_LEN - s/r pulse width in cycles (>=1)
//                HOLDOFF   - forced idle cycles after each pulse (>=0)
//  Ports       : clk - rising-edge clock
//                rst - asynchronous, active-low reset
//                bus - sr_cmd_seq_if.slave (set_in, clr_in, s, r, busy, err)
//  Option      : SR_CMD_SEQ_ERR_EN - when defined, err latches on a set/clr
//                conflict seen in IDLE or on a new edge into an already
//                pending channel; when undefined err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_cmd_seq #(
    parameter int DB_CYCLES = 4,
    parameter int PULSE_LEN = 1,
    parameter int HOLDOFF   = 3
) (
    input  wire logic   clk,
    input  wire logic   rst,
    sr_cmd_seq_if.slave bus
);

    localparam int c_cnt_w  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int c_ph_max = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
    localparam int c_ph_w   = (c_ph_max > 1) ? $clog2(c_ph_max) : 1;

    localparam logic [c_cnt_w-1:0] c_db_last    = c_cnt_w'(DB_CYCLES - 1);
    localparam logic [c_ph_w-1:0]  c_pulse_last = c_ph_w'(PULSE_LEN - 1);
    localparam logic [c_ph_w-1:0]  c_hold_last  = c_ph_w'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Channel index 0 = set, 1 = clear.
    logic [1:0] w_raw;
    logic [1:0] w_rise;
    logic [1:0] w_pend;
    logic [1:0] w_take;

    assign w_raw = {bus.clr_in, bus.set_in};

    // ------------------------------------------------------------------
    // Per-channel synchroniser, debouncer, edge capture and pending flag
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic               r_meta;
        logic               r_sy;
        logic               r_lvl;
        logic               r_lvl_d;
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_pend;

        assign w_rise[gi] = r_lvl & ~r_lvl_d;
        assign w_pend[gi] = r_pend;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_meta  <= 1'b0;
                r_sy    <= 1'b0;
                r_lvl   <= 1'b0;
                r_lvl_d <= 1'b0;
                r_cnt   <= '0;
                r_pend  <= 1'b0;
            end else begin
                r_meta  <= w_raw[gi];
                r_sy    <= r_meta;
                r_lvl_d <= r_lvl;

                if (r_sy == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    r_lvl <= r_sy;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end

                // A fresh edge in the same cycle the sequencer consumes the
                // old request is a new request, so setting has priority.
                if (w_rise[gi]) begin
                    r_pend <= 1'b1;
                end else if (w_take[gi]) begin
                    r_pend <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_cmd_clr;
    logic                w_cmd_clr_nxt;
    logic [c_ph_w-1:0]   r_ph_cnt;
    logic [c_ph_w-1:0]   w_ph_cnt_nxt;
    logic                r_s;
    logic                r_r;
    logic                r_busy;
    logic                w_s_nxt;
    logic                w_r_nxt;
    logic                w_busy_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_clr_nxt = r_cmd_clr;
        w_ph_cnt_nxt  = r_ph_cnt;
        w_take        = 2'b00;

        case (r_state)
            ST_IDLE: begin
                if (w_pend[1]) begin
                    // Clear wins; a simultaneous set request is dropped.
                    w_take        = 2'b11;
                    w_cmd_clr_nxt = 1'b1;
                    w_ph_cnt_nxt  = '0;
                    w_state_nxt   = ST_PULSE;
                end else if (w_pend[0]) begin
                    w_take        = 2'b01;
                    w_cmd_clr_nxt = 1'b0;
                    w_ph_cnt_nxt  = '0;
                    w_state_nxt   = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (r_ph_cnt == c_pulse_last) begin
                    w_ph_cnt_nxt = '0;
                    w_state_nxt  = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
                end else begin
                    w_ph_cnt_nxt = r_ph_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_ph_cnt == c_hold_last) begin
                    w_ph_cnt_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_ph_cnt_nxt = r_ph_cnt + 1'b1;
                end
            end
            default: begin
                w_ph_cnt_nxt = '0;
                w_state_nxt  = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so s/r/busy line up
        // exactly with the state they describe.
        w_s_nxt    = (w_state_nxt == ST_PULSE) & ~w_cmd_clr_nxt;
        w_r_nxt    = (w_state_nxt == ST_PULSE) &  w_cmd_clr_nxt;
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cmd_clr <= 1'b0;
            r_ph_cnt  <= '0;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd_clr <= w_cmd_clr_nxt;
            r_ph_cnt  <= w_ph_cnt_nxt;
            r_s       <= w_s_nxt;
            r_r       <= w_r_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.s    = r_s;
    assign bus.r    = r_r;
    assign bus.busy = r_busy;

    // ------------------------------------------------------------------
    // Optional sticky conflict flag
    // ------------------------------------------------------------------
`ifdef SR_CMD_SEQ_ERR_EN
    logic       r_err;
    logic [1:0] w_dup;
    logic       w_err_set;

    // An edge into a channel whose request is being consumed this cycle
    // is a new request, not a duplicate.
    assign w_dup     = w_rise & w_pend & ~w_take;
    assign w_err_set = ((r_state == ST_IDLE) & w_pend[0] & w_pend[1]) | (|w_dup);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_cmd_seq
//  Description : Self-checking bench for sr_cmd_seq at DB_CYCLES=4,
//                PULSE_LEN=1, HOLDOFF=3. Expected pulse starts are queued
//                when stimulus is applied and compared as pulses appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_cmd_seq;

`ifdef SR_CMD_SEQ_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    sr_cmd_seq_if bus ();

    sr_cmd_seq #(
        .DB_CYCLES (4),
        .PULSE_LEN (1),
        .HOLDOFF   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        bit is_set;
        int cyc;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input int kind, input int at);
        exp_t e;
        if (kind != 0) begin
            e.is_set = (kind == 1);
            e.cyc    = at;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start(input bit is_set);
        exp_t e;
        if (sb.size() == 0) begin
            chk(is_set ? "unexpected_s_pulse" : "unexpected_r_pulse", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("pulse_is_set", int'(is_set), int'(e.is_set));
            chk("pulse_start_cycle", cyc, e.cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int   busy_total = 0;
    logic s_q = 1'b0;
    logic r_q = 1'b0;
    int   s_len = 0;
    int   r_len = 0;

    always @(negedge clk) begin
        if (bus.s & bus.r) chk("s_and_r_exclusive", 1, 0);
        if (bus.busy) busy_total++;
        if (bus.s && !s_q) pulse_start(1'b1);
        if (bus.r && !r_q) pulse_start(1'b0);
        if (bus.s) s_len++;
        else begin
            if (s_q) chk("s_width", s_len, 1);
            s_len = 0;
        end
        if (bus.r) r_len++;
        else begin
            if (r_q) chk("r_width", r_len, 1);
            r_len = 0;
        end
        s_q = bus.s;
        r_q = bus.r;
    end

    // ---------------- vectors ----------------
    // kind: 0 none, 1 s pulse, 2 r pulse; cycles relative to stimulus start
    typedef struct {
        string name;
        int    sd, sl, cd, cl;
        int    k1, c1, k2, c2;
        int    e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int t0;
        int b0;
        int npulse;

        bus.set_in = 1'b0;
        bus.clr_in = 1'b0;
        rst        = 1'b0;

        // Reset held while inputs toggle: outputs stay low.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.set_in = k[0];
            bus.clr_in = ~k[0];
            #1;
            if (k == 1 || k == 5) begin
                chk("rst_s",    int'(bus.s),    0);
                chk("rst_r",    int'(bus.r),    0);
                chk("rst_busy", int'(bus.busy), 0);
                chk("rst_err",  int'(bus.err),  0);
            end
        end
        bus.set_in = 1'b0;
        bus.clr_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        b0  = busy_total;
        repeat (20) @(negedge clk);
        chk("rst_release_no_pulse", sb.size(), 0);
        chk("rst_release_busy", busy_total - b0, 0);

        vecs[0] = '{"set_cmd",      0, 12,  0,  0, 1,  8, 0,  0, 0};
        vecs[1] = '{"clr_cmd",      0,  0,  0, 12, 2,  8, 0,  0, 0};
        vecs[2] = '{"clr_glitch3",  0,  0,  0,  3, 0,  0, 0,  0, 0};
        vecs[3] = '{"set_min4",     0,  4,  0,  0, 1,  8, 0,  0, 0};
        vecs[4] = '{"simultaneous", 0, 12,  0, 12, 2,  8, 0,  0, 1};
        vecs[5] = '{"clr_in_hold",  0, 12,  3, 12, 1,  8, 2, 13, 0};
        vecs[6] = '{"clr_late",     0, 12, 10, 12, 1,  8, 2, 18, 0};
        vecs[7] = '{"clr_in_pulse", 0, 12,  1, 12, 1,  8, 2, 13, 0};
        vecs[8] = '{"clr_then_set", 1, 12,  0, 12, 2,  8, 1, 13, 0};
        vecs[9] = '{"quiet",        0,  0,  0,  0, 0,  0, 0,  0, 0};

        for (int v = 0; v < 10; v++) begin
            do_reset();
            sb.delete();
            t0 = cyc;
            b0 = busy_total;
            push_exp(vecs[v].k1, t0 + vecs[v].c1);
            push_exp(vecs[v].k2, t0 + vecs[v].c2);
            npulse = int'(vecs[v].k1 != 0) + int'(vecs[v].k2 != 0);
            for (int k = 0; k < 40; k++) begin
                bus.set_in = (k >= vecs[v].sd) && (k < vecs[v].sd + vecs[v].sl);
                bus.clr_in = (k >= vecs[v].cd) && (k < vecs[v].cd + vecs[v].cl);
                @(negedge clk);
            end
            chk({vecs[v].name, "_all_pulses_seen"}, sb.size(), 0);
            chk({vecs[v].name, "_busy_cycles"}, busy_total - b0, 4 * npulse);
            chk({vecs[v].name, "_err"}, int'(bus.err), vecs[v].e_err * ERR_EN);
        end

        // Reset while s is high with a clear pending: s drops at once and
        // the pending clear is lost.
        do_reset();
        sb.delete();
        t0 = cyc;
        push_exp(1, t0 + 8);
        for (int k = 0; k < 8; k++) begin
            bus.set_in = 1'b1;
            bus.clr_in = (k >= 1);
            @(negedge clk);
        end
        chk("midrst_s_before", int'(bus.s), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_s_drop",    int'(bus.s),    0);
        chk("midrst_busy_drop", int'(bus.busy), 0);
        bus.set_in = 1'b0;
        bus.clr_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        b0  = busy_total;
        repeat (30) @(negedge clk);
        chk("midrst_no_late_pulse", sb.size(), 0);
        chk("midrst_busy", busy_total - b0, 0);

        // Input held high across reset release: one command, normal latency.
        @(negedge clk);
        rst        = 1'b0;
        bus.set_in = 1'b1;
        repeat (3) @(negedge clk);
        sb.delete();
        rst = 1'b1;
        t0  = cyc;
        b0  = busy_total;
        push_exp(1, t0 + 8);
        repeat (30) @(negedge clk);
        bus.set_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_release_one_pulse", sb.size(), 0);
        chk("held_release_busy", busy_total - b0, 4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
